// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Sequencer that owns the newPC / WE / W_Ins / RST inputs of the IF stage.
//
// In RUN it picks the next fetch address: an aligned branch target, the
// current PC when stalled, or the sequential PC+4. A start_load pulse
// switches it into a program-load sequence:
//   ASM     collect 4 bytes over rx_valid/rx_ready, packed MSB-first
//   ADDR    drive newPC with the target word address so IF latches it
//   WR      one-cycle WE with the assembled word at the latched PC
//   RESTART one-cycle CPU reset so fetch restarts at address 0
// A done pulse follows RESTART and the block returns to RUN.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   start_load, load_len  load request and word count (sampled in RUN)
//   rx_valid, rx_data,    byte stream, accepted on rx_valid && rx_ready
//   rx_ready
//   PC, nextPC            current PC and PC+4 from IF
//   stall, br_taken,      RUN-mode next-PC controls
//   br_target
//   newPC, WE, W_Ins      to IF
//   cpu_rst               to IF RST (RST or internal restart)
//   busy                  high outside RUN; downstream treats Ins as bubble
//   done                  one-cycle pulse at the end of a load
//   err                   sticky: misaligned branch or oversize load_len
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int IMEM_WORDS = 1024,
    parameter int LEN_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic [31:0]      PC,
    input  logic [31:0]      nextPC,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      newPC,
    output logic             WE,
    output logic [31:0]      W_Ins,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Word address width; the byte-address padding below assumes AW < 30.
    localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int PAD = 30 - AW;
    localparam logic [31:0] MAX_LEN = 32'(IMEM_WORDS);

    typedef enum logic [2:0] {
        S_RUN,
        S_ASM,
        S_ADDR,
        S_WR,
        S_RESTART
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q;
    logic [AW-1:0]    waddr_q;
    logic [LEN_W-1:0] wcnt_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      word_q;
    logic             err_q;
    logic             done_q;

    logic [31:0]      len_ext;
    logic             start_zero;
    logic             start_big;
    logic             start_go;
    logic             misalign;
    logic             rx_fire;
    logic             last_word;
    logic [31:0]      waddr_pc;
    logic [31:0]      newpc_c;

    assign len_ext    = {{(32-LEN_W){1'b0}}, load_len};
    assign start_zero = start_load && (load_len == '0);
    assign start_big  = start_load && (len_ext > MAX_LEN);
    assign start_go   = start_load && !start_zero && !start_big;
    assign misalign   = br_taken && (br_target[1:0] != 2'b00);

    assign rx_ready   = (state_q == S_ASM) && !RST;
    assign rx_fire    = rx_valid && rx_ready;
    assign last_word  = (wcnt_q == (len_q - LEN_W'(1)));
    assign waddr_pc   = {{PAD{1'b0}}, waddr_q, 2'b00};

    // Combinational outputs are forced to their reset values while RST is
    // high so IF sees a clean reset even before the state register clears.
    assign WE      = (state_q == S_WR) && !RST;
    assign busy    = (state_q != S_RUN) && !RST;
    assign cpu_rst = RST || (state_q == S_RESTART);
    assign W_Ins   = RST ? 32'h0 : word_q;
    assign newPC   = RST ? 32'h0 : newpc_c;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        newpc_c = PC;
        case (state_q)
            S_RUN: begin
                // Branch redirect outranks stall; low target bits are dropped.
                if (br_taken) begin
                    newpc_c = {br_target[31:2], 2'b00};
                end else if (stall) begin
                    newpc_c = PC;
                end else begin
                    newpc_c = nextPC;
                end
                if (start_go) begin
                    state_d = S_ASM;
                end
            end
            S_ASM: begin
                if (rx_fire && (byte_cnt_q == 2'd3)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // IF latches this address on the edge that leaves ADDR.
                newpc_c = waddr_pc;
                state_d = S_WR;
            end
            S_WR: begin
                state_d = last_word ? S_RESTART : S_ASM;
            end
            S_RESTART: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_cnt_q <= 2'd0;
            waddr_q    <= '0;
            wcnt_q     <= '0;
            len_q      <= '0;
            word_q     <= 32'h0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (misalign) begin
                        err_q <= 1'b1;
                    end
                    // An accepted load request clears err, overriding any
                    // misaligned branch seen in the same cycle.
                    if (start_zero) begin
                        done_q <= 1'b1;
                    end else if (start_big) begin
                        err_q <= 1'b1;
                    end else if (start_go) begin
                        len_q      <= load_len;
                        err_q      <= 1'b0;
                        waddr_q    <= '0;
                        wcnt_q     <= '0;
                        byte_cnt_q <= 2'd0;
                    end
                end
                S_ASM: begin
                    if (rx_fire) begin
                        word_q     <= {word_q[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WR: begin
                    wcnt_q     <= wcnt_q + LEN_W'(1);
                    byte_cnt_q <= 2'd0;
                    // Hold waddr on the final word so a full-depth load
                    // finishes at the last address instead of wrapping.
                    if (!last_word) begin
                        waddr_q <= waddr_q + AW'(1);
                    end
                end
                S_RESTART: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
